// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter's wen/din/rdy handshake.
// Bytes enter at up to one per clock and drain one frame at a time in strict order.
module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          tx_wen,
   output logic [DW-1:0] tx_din,
   input  logic          tx_rdy
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count_nxt;
   logic          wr_ok, launch;

   // full is the registered value, so a pop in the same cycle cannot make room
   assign wr_ok = wr_en & ~full;

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      case (state)
         IDLE: if (!empty && tx_rdy) begin
            launch    = 1'b1;
            state_nxt = SEND;
         end
         SEND: if (tx_rdy) state_nxt = HOLD;
         // wait out the frame so one accepted byte never launches twice
         HOLD: if (tx_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      if (wr_ok && !launch)      count_nxt = count + 1'b1;
      else if (!wr_ok && launch) count_nxt = count - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (wr_ok) mem[wptr] <= wr_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         tx_wen   <= 1'b0;
         tx_din   <= '1;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         full   <= (count_nxt == DEPTH_C);
         empty  <= (count_nxt == '0);
         tx_wen <= (state_nxt == SEND);
         if (wr_ok) wptr <= wptr + 1'b1;
         if (wr_en && full) overflow <= 1'b1;
         if (launch) begin
            rptr   <= rptr + 1'b1;
            tx_din <= mem[rptr];
         end
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the system at up to one per clock into a 2^AW-entry FIFO. It then drains them one at a time into the transmitter's `wen`/`din`/`rdy` handshake, so software or a producer block never has to wait on a serial frame. Drain order is strict FIFO.

## Interface
- `DW`, 8: data width; must match the transmitter's `DW`.
- `AW`, 4: FIFO address width; depth = 2^AW entries (16).
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset; synchronous, active-high. One clock, no other reset.
- `wr_en`  in  1  write strobe; one byte per cycle while high.
- `wr_data`  in  DW  byte to enqueue.
- `full`  out  1  FIFO holds 2^AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  AW+1  current occupancy, 0..2^AW.
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_wen`  out  1  to transmitter `wen`; registered.
- `tx_din`  out  DW  to transmitter `din`; registered, stable while `tx_wen`=1.
- `tx_rdy`  in  1  from transmitter `rdy` (idle when 1).

## Operation
- **Storage:** circular buffer of 2^AW × DW.
  - `wptr` and `rptr` are AW bits and wrap modulo 2^AW.
  - `count` is AW+1 bits.
  - `full`/`empty` are decoded from registered `count` only, never from pointers.
- **Write:** when `wr_en`=1 and `full`=0 (current-cycle value), store `wr_data` at `wptr` and increment `wptr`.
  - When `wr_en`=1 and `full`=1, drop the byte and set `overflow`=1. `overflow` clears only on `RST`.
- **Pop:** only in state IDLE on a launch (see below). Read `mem[rptr]` into `tx_din` and increment `rptr`.
- **Count update:** +1 on write only, −1 on pop only, unchanged on simultaneous write+pop or on neither.
  - A simultaneous write+pop while full: the write is dropped because `full` is evaluated before the pop; `count` goes 2^AW→2^AW−1.
  - A pop never occurs while empty, so write+pop at empty is impossible.
- **Drain FSM** (3 states):
  - **IDLE:** `tx_wen`=0. If `empty`=0 and `tx_rdy`=1: pop, `tx_din`←head, `tx_wen`←1, go to SEND. Otherwise stay.
  - **SEND:** `tx_wen`=1. The transmitter accepts in any cycle where `tx_rdy`=1.
    - If `tx_rdy`=1: `tx_wen`←0, go to HOLD.
    - If `tx_rdy`=0: stay in SEND with `tx_wen` and `tx_din` held.
  - **HOLD:** `tx_wen`=0. The transmitter drops `rdy` the cycle after accepting. Stay while `tx_rdy`=0; go to IDLE on the first cycle `tx_rdy`=1.
    - This state guarantees exactly one accepted `wen`&`rdy` cycle per popped byte, with no duplicate launch.
- `tx_din` changes only on the IDLE→SEND transition. Between frames it holds the last byte.

## Timing
- **Reset values:** `count`=0, `empty`=1, `full`=0, `overflow`=0, `tx_wen`=0, `tx_din`=all ones, FSM=IDLE, `wptr`=`rptr`=0. Memory contents are don't-care.
- **Reset mid-operation:**
  - All queued bytes are discarded.
  - `tx_wen` is 0 from the cycle after `RST` is sampled.
  - A frame already accepted downstream is not aborted by this block.
- **Write latency:** `count`/`empty`/`full` update at the edge that samples `wr_en`. With the transmitter idle, a write into an empty FIFO at edge N gives:
  - `empty`=0 after edge N;
  - IDLE launch at edge N+1, so `tx_wen`=1 during cycle N+1..N+2;
  - transmitter start at edge N+2.
- **Back-to-back frames:** the next launch occurs at the first IDLE cycle after `tx_rdy` returns to 1, i.e. 2 cycles after `rdy` rises. The gap between frames is therefore frame time + 3 cycles.
- **Outputs:** `full`, `empty`, `count`, `overflow`, `tx_wen`, `tx_din` are all registered. The only combinational path to them is `tx_rdy`/`wr_en` → next-state logic.

## Test plan
- **Single byte:** after reset, write 0xA5 once with a real transmitter model (SLOOP_MAX=3).
  - `tx_wen` is high for exactly 1 cycle with `tx_din`=0xA5.
  - TX line shows start bit, then 1,0,1,0,0,1,0,1 LSB-first, then stop.
  - `count` goes 1→0 at launch; `empty`=1 afterwards.
- **Fill to full:** write 0x00..0x0F on 16 consecutive cycles with `tx_rdy` held 0.
  - `count`=16, `full`=1, `overflow`=0.
  - Then write 0x10: it is dropped, `overflow`=1, `count`=16.
  - Release `tx_rdy`: bytes 0x00..0x0F emerge in order; 0x10 never appears.
- **Write while full:** at full, with FSM in IDLE and `tx_rdy`=1, assert `wr_en` with 0x55 in the launch cycle.
  - The write is dropped, `overflow`=1, `count`=15.
- **Stalled accept:** force `tx_rdy`=0 during SEND for 5 cycles.
  - `tx_wen` stays 1 and `tx_din` is stable.
  - The accept happens on the cycle `tx_rdy` returns to 1.
  - Exactly one pop occurs.
- **Wrap-around:** perform 40 writes interleaved with drains so that pointers wrap at least twice.
  - Output sequence equals input sequence; `count` never exceeds 16.
- **Mid-burst reset:** queue 8 bytes, then assert `RST` for 1 cycle during HOLD.
  - Next cycle: `count`=0, `empty`=1, `tx_wen`=0, `overflow`=0.
  - No further `tx_wen` pulses occur after the in-flight frame.
